truncf: RTL and testbench

Pipelined IEEE-754 binary64 to binary32 floating-point truncation unit with an elastic valid/ready handshake; the narrowing counterpart of the float extension operator. It sits in the arith operator library as the Verilog implementation of the `truncf` dataflow operation. It accepts one token per cycle and produces a correctly rounded (round-to-nearest-even) single-precision result two cycles later. It handles NaN, infinity, overflow, subnormal and zero cases natively, with no external IP.

---
 rtl/truncf_if.sv | 31 +++
 rtl/truncf.sv | 155 +++++++++++++++
 tb/tb_truncf.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/truncf_if.sv
// Elastic valid/ready bundle for the binary64 -> binary32 truncation operator.
// The master side produces operands and consumes results; the slave side is the operator.
interface truncf_if #(
    parameter int INPUT_TYPE  = 64,
    parameter int OUTPUT_TYPE = 32
);
    logic [INPUT_TYPE-1:0]  ins;
    logic                   ins_valid;
    logic                   ins_ready;
    logic [OUTPUT_TYPE-1:0] outs;
    logic                   outs_valid;
    logic                   outs_ready;

    modport master (
        output ins,
        output ins_valid,
        input  ins_ready,
        input  outs,
        input  outs_valid,
        output outs_ready
    );

    modport slave (
        input  ins,
        input  ins_valid,
        output ins_ready,
        output outs,
        output outs_valid,
        input  outs_ready
    );
endinterface

// File: rtl/truncf.sv
// Two-stage binary64 -> binary32 narrowing with round-to-nearest-even.
// Stage 1 unpacks and classifies, stage 2 rounds and packs; both stages are elastic.
module truncf #(
    parameter int INPUT_TYPE  = 64,
    parameter int OUTPUT_TYPE = 32
) (
    input  logic    clk,
    input  logic    rst,
    truncf_if.slave bus
);

    localparam logic [2:0] CLS_ZERO = 3'd0;
    localparam logic [2:0] CLS_INF  = 3'd1;
    localparam logic [2:0] CLS_NAN  = 3'd2;
    localparam logic [2:0] CLS_NORM = 3'd3;
    localparam logic [2:0] CLS_SUB  = 3'd4;

    // Round-to-nearest-even on the packed {exponent, mantissa}; a mantissa carry
    // deliberately ripples into the exponent (subnormal->normal, max->infinity).
    function automatic logic [30:0] round_rne(input logic [30:0] em,
                                              input logic g,
                                              input logic t);
        logic inc;
        inc = g & (t | em[0]);
        return em + {30'd0, inc};
    endfunction

    function automatic logic [OUTPUT_TYPE-1:0] pack(input logic [2:0]  cls,
                                                    input logic        s,
                                                    input logic [7:0]  ef,
                                                    input logic [22:0] m,
                                                    input logic        g,
                                                    input logic        t);
        logic [OUTPUT_TYPE-1:0] r;
        case (cls)
            CLS_NAN:  r = {s, 8'hFF, m};
            CLS_INF:  r = {s, 8'hFF, 23'd0};
            CLS_NORM,
            CLS_SUB:  r = {s, round_rne({ef, m}, g, t)};
            default:  r = {s, 31'd0};
        endcase
        return r;
    endfunction

    logic                   en1;
    logic                   en2;

    logic [INPUT_TYPE-1:0]  din;
    logic                   s_c;
    logic [10:0]            ex_c;
    logic [51:0]            fr_c;
    logic signed [12:0]     e_c;
    logic signed [12:0]     neg_e_c;
    logic [4:0]             sh_c;
    logic [86:0]            wide_c;
    logic [2:0]             cls_c;
    logic [7:0]             ef_c;
    logic [22:0]            m_c;
    logic                   g_c;
    logic                   t_c;

    logic                   vld_p1;
    logic [2:0]             cls_p1;
    logic                   s_p1;
    logic [7:0]             ef_p1;
    logic [22:0]            m_p1;
    logic                   g_p1;
    logic                   t_p1;

    logic                   vld_p2;
    logic [OUTPUT_TYPE-1:0] res_p2;

    assign en2           = !vld_p2 || bus.outs_ready;
    assign en1           = !vld_p1 || en2;
    assign bus.ins_ready = en1;
    assign bus.outs      = res_p2;
    assign bus.outs_valid = vld_p2;

    assign din  = bus.ins;
    assign s_c  = din[63];
    assign ex_c = din[62:52];
    assign fr_c = din[51:0];
    assign e_c  = $signed({2'b00, ex_c}) - 13'sd896;
    assign neg_e_c = -e_c;

    // A subnormal result needs {1,F} >> min(30-e, 55). The first 30 positions of
    // that shift are fixed, so only the remaining min(-e, 25) is variable and the
    // window below keeps just the 23 kept bits plus 64 shifted-out bits.
    assign sh_c   = (neg_e_c > 13'sd25) ? 5'd25 : neg_e_c[4:0];
    assign wide_c = {1'b1, fr_c, 34'd0} >> sh_c;

    always_comb begin
        cls_c = CLS_ZERO;
        ef_c  = 8'd0;
        m_c   = 23'd0;
        g_c   = 1'b0;
        t_c   = 1'b0;
        if (ex_c == 11'h7FF) begin
            if (fr_c != 52'd0) begin
                cls_c = CLS_NAN;
                m_c   = {1'b1, fr_c[50:29]};
            end else begin
                cls_c = CLS_INF;
            end
        end else if (ex_c == 11'd0) begin
            cls_c = CLS_ZERO;
        end else if (e_c >= 13'sd255) begin
            cls_c = CLS_INF;
        end else if (e_c >= 13'sd1) begin
            cls_c = CLS_NORM;
            ef_c  = e_c[7:0];
            m_c   = fr_c[51:29];
            g_c   = fr_c[28];
            t_c   = |fr_c[27:0];
        end else begin
            cls_c = CLS_SUB;
            m_c   = wide_c[86:64];
            g_c   = wide_c[63];
            t_c   = |wide_c[62:0];
        end
    end

    // Stage 1: classified operand fields
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            cls_p1 <= CLS_ZERO;
            s_p1   <= 1'b0;
            ef_p1  <= 8'd0;
            m_p1   <= 23'd0;
            g_p1   <= 1'b0;
            t_p1   <= 1'b0;
        end else if (en1) begin
            vld_p1 <= bus.ins_valid;
            cls_p1 <= cls_c;
            s_p1   <= s_c;
            ef_p1  <= ef_c;
            m_p1   <= m_c;
            g_p1   <= g_c;
            t_p1   <= t_c;
        end
    end

    // Stage 2: rounded and packed binary32 result
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2 <= 1'b0;
            res_p2 <= '0;
        end else if (en2) begin
            vld_p2 <= vld_p1;
            res_p2 <= pack(cls_p1, s_p1, ef_p1, m_p1, g_p1, t_p1);
        end
    end

endmodule

// File: tb/tb_truncf.sv
// Directed bench for truncf: conversion vectors, RNE corner cases,
// backpressure ordering/stability and mid-flight reset.
module tb_truncf;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    truncf_if #(.INPUT_TYPE(64), .OUTPUT_TYPE(32)) bus ();

    truncf #(.INPUT_TYPE(64), .OUTPUT_TYPE(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] vin  [16];
    logic [31:0] vexp [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    task automatic send_one(input int idx);
        @(negedge clk);
        bus.ins        = vin[idx];
        bus.ins_valid  = 1'b1;
        bus.outs_ready = 1'b1;
        #1;
        chk($sformatf("rdy_%0d", idx), 64'(bus.ins_ready), 64'd1);
        @(negedge clk);
        bus.ins_valid = 1'b0;
        chk($sformatf("early_vld_%0d", idx), 64'(bus.outs_valid), 64'd0);
        @(negedge clk);
        chk($sformatf("vld_%0d", idx), 64'(bus.outs_valid), 64'd1);
        chk($sformatf("res_%0d", idx), 64'(bus.outs), 64'(vexp[idx]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        int recv;
        int cyc;
        logic stalled;
        logic [31:0] held;
        logic [31:0] pat;

        vin[0]  = 64'h3FF0000000000000; vexp[0]  = 32'h3F800000;
        vin[1]  = 64'hC000000000000000; vexp[1]  = 32'hC0000000;
        vin[2]  = 64'h8000000000000000; vexp[2]  = 32'h80000000;
        vin[3]  = 64'h3FF0000010000000; vexp[3]  = 32'h3F800000;
        vin[4]  = 64'h3FF0000030000000; vexp[4]  = 32'h3F800002;
        vin[5]  = 64'h3FF0000010000001; vexp[5]  = 32'h3F800001;
        vin[6]  = 64'h47F0000000000000; vexp[6]  = 32'h7F800000;
        vin[7]  = 64'h47EFFFFFF0000000; vexp[7]  = 32'h7F800000;
        vin[8]  = 64'hFFF0000000000000; vexp[8]  = 32'hFF800000;
        vin[9]  = 64'h36A0000000000000; vexp[9]  = 32'h00000001;
        vin[10] = 64'h3690000000000000; vexp[10] = 32'h00000000;
        vin[11] = 64'h3690000000000001; vexp[11] = 32'h00000001;
        vin[12] = 64'h380FFFFFF0000000; vexp[12] = 32'h00800000;
        vin[13] = 64'h0000000000000001; vexp[13] = 32'h00000000;
        vin[14] = 64'h7FF0000000000001; vexp[14] = 32'h7FC00000;
        vin[15] = 64'hFFF8000020000000; vexp[15] = 32'hFFC00001;

        rst            = 1'b1;
        bus.ins        = '0;
        bus.ins_valid  = 1'b0;
        bus.outs_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_vld", 64'(bus.outs_valid), 64'd0);
        chk("reset_outs", 64'(bus.outs), 64'd0);
        chk("reset_rdy", 64'(bus.ins_ready), 64'd1);

        for (int i = 0; i < 16; i++) send_one(i);

        sent    = 0;
        recv    = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        pat     = 32'hB3A56C9D;
        while (recv < 8 && cyc < 200) begin
            @(negedge clk);
            bus.outs_ready = (cyc >= 6 && cyc < 11) ? 1'b0 : pat[cyc % 32];
            bus.ins_valid  = (sent < 8);
            bus.ins        = vin[sent];
            #1;
            if (stalled) begin
                chk("stall_vld", 64'(bus.outs_valid), 64'd1);
                chk("stall_data", 64'(bus.outs), 64'(held));
            end
            chk("bp_rdy", 64'(bus.ins_ready), 64'(!((sent - recv) == 2 && !bus.outs_ready)));
            if (bus.outs_valid && bus.outs_ready) begin
                chk($sformatf("bp_out_%0d", recv), 64'(bus.outs), 64'(vexp[recv]));
                recv++;
            end
            stalled = bus.outs_valid && !bus.outs_ready;
            held    = bus.outs;
            if (bus.ins_valid && bus.ins_ready) sent++;
            cyc++;
        end
        chk("bp_count", 64'(recv), 64'd8);

        @(negedge clk);
        bus.ins_valid  = 1'b0;
        bus.outs_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Two tokens parked in the pipe, then a one-cycle reset.
        bus.outs_ready = 1'b0;
        bus.ins_valid  = 1'b1;
        bus.ins        = vin[0];
        @(negedge clk);
        bus.ins        = vin[1];
        @(negedge clk);
        bus.ins_valid  = 1'b0;
        #1;
        chk("full_vld", 64'(bus.outs_valid), 64'd1);
        chk("full_rdy", 64'(bus.ins_ready), 64'd0);
        chk("full_outs", 64'(bus.outs), 64'(vexp[0]));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.outs_ready = 1'b1;
        #1;
        chk("mid_rst_vld", 64'(bus.outs_valid), 64'd0);
        chk("mid_rst_outs", 64'(bus.outs), 64'd0);
        chk("mid_rst_rdy", 64'(bus.ins_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("stale_%0d", k), 64'(bus.outs_valid), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
